// File: rtl/memory_sync_ram_if.sv
// Access bus of the clocked single-port RAM: request fields from the master,
// registered read data and status back from the RAM.
interface memory_sync_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  select;
  logic                  rw;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  parity_error;

  modport master (
    output address, data_in, select, rw,
    input  data_out, data_valid, busy, parity_error
  );

  modport slave (
    input  address, data_in, select, rw,
    output data_out, data_valid, busy, parity_error
  );
endinterface

// File: rtl/memory_sync_ram.sv
// Clocked single-port RAM with a post-reset clear sequencer and registered read path.
// Optional per-word even parity is enabled by defining MEMORY_PARITY_EN.
module memory_sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  memory_sync_ram_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH:0]   clr_cnt_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_valid_r;
  logic                  parity_error_r;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

`ifdef MEMORY_PARITY_EN
  logic                  par_mem_r [DEPTH];
  logic                  mem_wpar_s;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  // Clear writes a zero word, whose even parity is also zero
  assign mem_wpar_s = (state_r == ST_READY) ? even_parity(bus.data_in) : 1'b0;
`endif

  // Write port select: clear sequencer owns the array until READY
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s   = 1'b1;
        mem_addr_s = clr_cnt_r[ADDR_WIDTH-1:0];
      end
      ST_READY: begin
        if (bus.select == 1'b1 && bus.rw == 1'b1) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = bus.address;
          mem_wdata_s = bus.data_in;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: mem_we_s = 1'b0;
    endcase
  end

  // Storage array; contents are only initialised by the clear sequence
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
`ifdef MEMORY_PARITY_EN
      par_mem_r[mem_addr_s] <= mem_wpar_s;
`endif
    end
  end

  // Control FSM with registered read data and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_CLEAR;
      clr_cnt_r      <= '0;
      busy_r         <= 1'b1;
      data_out_r     <= '0;
      data_valid_r   <= 1'b0;
      parity_error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          data_valid_r   <= 1'b0;
          parity_error_r <= 1'b0;
          clr_cnt_r      <= clr_cnt_r + 1'b1;
          if (clr_cnt_r == LAST_CNT) begin
            state_r <= ST_READY;
            busy_r  <= 1'b0;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        ST_READY: begin
          busy_r <= 1'b0;
          if (bus.select == 1'b1 && bus.rw == 1'b0) begin
            data_out_r   <= mem_r[bus.address];
            data_valid_r <= 1'b1;
`ifdef MEMORY_PARITY_EN
            parity_error_r <= even_parity(mem_r[bus.address]) ^ par_mem_r[bus.address];
`else
            parity_error_r <= 1'b0;
`endif
          end else begin
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_CLEAR;
          clr_cnt_r      <= '0;
          busy_r         <= 1'b1;
          data_valid_r   <= 1'b0;
          parity_error_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.busy       = busy_r;
`ifdef MEMORY_PARITY_EN
  assign bus.parity_error = parity_error_r;
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_memory_sync_ram.sv
// Directed scoreboard bench for memory_sync_ram (DATA_WIDTH=8, ADDR_WIDTH=3).
// Expected read results are queued at request time and popped on data_valid.
module tb_memory_sync_ram;
  logic clk;
  logic rst_n;

  memory_sync_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  memory_sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model_mem  [8];
  logic       model_perr [8];
  logic [7:0] last_data;
  int         tests;
  int         fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      model_mem[i]  = 8'h00;
      model_perr[i] = 1'b0;
    end
  endtask

  // One clock cycle: drive request, apply model if accepted, check after the edge
  task automatic do_cycle(input logic sel, input logic wr, input logic [2:0] a,
                          input logic [7:0] d, input logic accept, input logic exp_busy);
    exp_t e;
    logic exp_v;
    bus.select  = sel;
    bus.rw      = wr;
    bus.address = a;
    bus.data_in = d;
    exp_v = accept && sel && !wr;
    if (accept && sel && wr) begin
      model_mem[a]  = d;
      model_perr[a] = 1'b0;
    end
    if (exp_v) begin
      e.data = model_mem[a];
      e.perr = model_perr[a];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("data_valid", {31'd0, bus.data_valid}, {31'd0, exp_v});
    check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
    if (exp_v && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_data = e.data;
      check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
      check("parity_error", {31'd0, bus.parity_error}, {31'd0, e.perr});
    end else begin
      check("parity_idle", {31'd0, bus.parity_error}, 32'd0);
    end
  endtask

  task automatic run_clear(input int n, input logic try_write);
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b1, (i == 0) ? try_write : 1'b0, 3'd2, 8'h55, 1'b0, (i < 7));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    last_data = 8'h00;
    model_clear();
    rst_n = 1'b0;
    bus.select = 1'b0;
    bus.rw = 1'b0;
    bus.address = 3'd0;
    bus.data_in = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd1);
    check("rst_parity", {31'd0, bus.parity_error}, 32'd0);

    // Clear sequence with a write of 8'h55 @2 and reads attempted while busy
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(8, 1'b1);

    // Every word reads zero, streamed back to back
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

    // Write AA @3 then read @3 on the next cycle
    do_cycle(1'b1, 1'b1, 3'd3, 8'hAA, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0);
    check("aa_hold", {24'd0, bus.data_out}, 32'h0000_00AA);

    // Streaming writes and reads, then hold with select low and X on address/rw
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b1, 3'(i), 8'(i + 1), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 1'bx, 3'bxxx, 8'hxx, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    check("stream_hold", {24'd0, bus.data_out}, 32'h0000_0008);
    check("stream_last", {24'd0, last_data}, 32'h0000_0008);
    do_cycle(1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0);

    // Reset mid-clear: restart and full clear again
    rst_n = 1'b0;
    model_clear();
    #2;
    check("rst2_data_out", {24'd0, bus.data_out}, 32'd0);
    check("rst2_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(4, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst3_busy", {31'd0, bus.busy}, 32'd1);
    check("rst3_valid", {31'd0, bus.data_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear(8, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b0);

`ifdef MEMORY_PARITY_EN
    // Corrupt the stored parity of word 5 and expect the error flag on read
    do_cycle(1'b1, 1'b1, 3'd5, 8'h0F, 1'b1, 1'b0);
    dut.par_mem_r[5] = ~dut.par_mem_r[5];
    model_perr[5] = 1'b1;
    do_cycle(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
`else
    do_cycle(1'b1, 1'b1, 3'd5, 8'h0F, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
